plic_gateway: RTL and testbench
===============================

# plic_gateway

Per-source interrupt gateway between the platform interrupt lines (PBUS GPIO-in, TIM0, TIM1, UART on PLIC lines 1–4; spare lines up to 31) and the PLIC core (priority/threshold/claim logic). It converts each level or edge source into at most one outstanding request, blocks re-requests until the PLIC core signals completion, and counts edges that arrive while a request is outstanding. PLIC line 0 is reserved and never requests.

## Interface

Parameters:
- `NUM_SOURCES`, 32: PLIC source lines including reserved line 0.
- `ID_WIDTH`, 5: width of claim/complete IDs; equals $clog2(NUM_SOURCES).
- `EDGE_MASK`, `PLIC_EDGE_MASK` (package): per-source trigger type; 1 = rising-edge, 0 = level-high.
- `EDGE_CNT_W`, 3: width of each per-source pending-edge counter.

Ports:
- `clock_i`, in, 1: system clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `src_i`, in, NUM_SOURCES: raw interrupt lines, synchronous to `clock_i`; bit 0 ignored.
- `claim_valid_i`, in, 1: PLIC core claims source `claim_id_i` this cycle.
- `claim_id_i`, in, ID_WIDTH: claimed source ID.
- `complete_valid_i`, in, 1: hart completion for source `complete_id_i`.
- `complete_id_i`, in, ID_WIDTH: completed source ID.
- `req_o`, out, NUM_SOURCES: request pending toward the PLIC core; bit 0 constant 0.
- `claimed_o`, out, NUM_SOURCES: source claimed and in service.
- `edge_ovf_o`, out, NUM_SOURCES: sticky flag, edge counter saturated and an edge was lost.

## Operation

- Per source, a state machine with states IDLE, REQ, and CLAIMED. `req_o[i]` = (state == REQ). `claimed_o[i]` = (state == CLAIMED).
- **Trigger, level:** `trig = src_i[i]`.
- **Trigger, edge:** `src_q[i]` registers `src_i[i]`. The rise condition is `src_i & ~src_q`. Each rise increments `cnt[i]`, saturating at 2^EDGE_CNT_W−1. A rise while `cnt[i]` is saturated sets `edge_ovf_o[i]`. `trig = (cnt != 0)`.
- **IDLE → REQ** when `trig`. In edge mode, `cnt` decrements on this transition. A simultaneous rise and decrement leaves `cnt` unchanged.
- **REQ → CLAIMED** on `claim_valid_i` with `claim_id_i == i`.
- **CLAIMED → IDLE** on `complete_valid_i` with `complete_id_i == i`. IDLE re-evaluates `trig` in the following cycle.
- A level source that drops while in REQ stays in REQ. The gateway never retracts a request.
- Ignored without any state change:
  - a claim for a source not in REQ;
  - a completion for a source not in CLAIMED;
  - any ID of 0 or ≥ NUM_SOURCES.
- Claim and complete for different IDs in the same cycle are both applied.
- Source 0 is held permanently in IDLE, with count 0 and no overflow.

## Timing

- **Reset values:**
  - all states IDLE, `req_o` = 0, `claimed_o` = 0;
  - `cnt` = 0, `edge_ovf_o` = 0;
  - `src_q` = 0. An edge source already high in the first cycle after reset counts as one rise.
- **Latency, trigger to request:**
  - Level source high in cycle t (IDLE): `req_o` is high in t+1.
  - Edge rise in cycle t: `cnt` is updated in t+1, and `req_o` is high in t+2.
- **Latency, claim:** claim in cycle t → `req_o` low and `claimed_o` high in t+1.
- **Latency, complete:** complete in cycle t → IDLE in t+1. If `trig` still holds, `req_o` is high again in t+2, giving a one-cycle bubble.
- **Reset mid-operation:** reset in any state returns every source to IDLE in the next cycle. Counts and overflow flags are lost, and any in-flight claim is dropped.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure

- **Additions to `uninasoc_pkg`:**
  - `PLIC_NUM_SOURCES` = 32 and `PLIC_ID_WIDTH` = 5;
  - `plic_gw_state_t` enum {IDLE, REQ, CLAIMED};
  - `PLIC_EDGE_MASK`, a 32-bit constant that marks the UART and timer lines as edge. Line indices come from the existing `PLIC_*_INTERRUPT` constants.
- **Sub-module:** `plic_gateway_cell` holds one source's state machine, edge register, counter and overflow flag. The top level generates instances 1..NUM_SOURCES−1, decodes the claim and completion IDs to one-hot vectors, and ties bit 0 to zero.

## Test plan

- **Level source:** hold `src_i[4]` high, claim ID 4 in the cycle after `req_o[4]` rises, complete two cycles later with the line still high → `req_o[4]` rises again two cycles after the completion. Drop the line, then complete → the source stays IDLE.
- **Edge counting:** with source 2 configured as edge, give three rises while it is CLAIMED, then run three claim/complete rounds → exactly three further requests, then `cnt` = 0.
- **Overflow:** with source 2 configured as edge and CLAIMED, give nine rises with EDGE_CNT_W = 3 → `cnt` = 7 and `edge_ovf_o[2]` = 1 until reset.
- **Illegal IDs:** claim ID 0, claim ID 3 while it is IDLE, and complete ID 1 while it is in REQ → no state change and no `req_o` change.
- **Simultaneous events:** claim ID 1 and complete ID 3 in the same cycle → both are applied. A rise on an edge source in the same cycle as its IDLE→REQ transition → `cnt` unchanged.
- **Reset mid-operation:** assert `reset_i` with sources in REQ and CLAIMED and nonzero counts → all outputs are 0 the next cycle. An edge line still high after reset produces one request.

Source files
------------

// File: rtl/uninasoc_pkg.sv
// Platform-wide constants and types; this slice carries the PLIC gateway additions.
package uninasoc_pkg;

  localparam int unsigned PLIC_GPIOIN_INTERRUPT = 1;
  localparam int unsigned PLIC_TIM0_INTERRUPT   = 2;
  localparam int unsigned PLIC_TIM1_INTERRUPT   = 3;
  localparam int unsigned PLIC_UART_INTERRUPT   = 4;

  localparam int unsigned PLIC_NUM_SOURCES = 32;
  localparam int unsigned PLIC_ID_WIDTH    = 5;

  // Timers and UART pulse their lines, so they are captured as rising edges.
  localparam logic [PLIC_NUM_SOURCES-1:0] PLIC_EDGE_MASK =
      (PLIC_NUM_SOURCES'(1) << PLIC_TIM0_INTERRUPT) |
      (PLIC_NUM_SOURCES'(1) << PLIC_TIM1_INTERRUPT) |
      (PLIC_NUM_SOURCES'(1) << PLIC_UART_INTERRUPT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CLAIMED
  } plic_gw_state_t;

endpackage

// File: rtl/plic_gateway_cell.sv
// One PLIC source: request state machine plus, for edge sources, a saturating
// pending-edge counter and sticky overflow flag.
module plic_gateway_cell
  import uninasoc_pkg::*;
#(
  parameter bit          EDGE  = 1'b0,
  parameter int unsigned CNT_W = 3
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic src_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic req_o,
  output logic claimed_o,
  output logic edge_ovf_o
);

  plic_gw_state_t   state_q, state_d;
  logic             src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rise, sat, trig, take;

  always_comb begin
    src_d   = src_i;
    rise    = EDGE && src_i && !src_q;
    sat     = &cnt_q;
    trig    = EDGE ? (cnt_q != '0) : src_i;
    take    = (state_q == IDLE) && trig;
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q | (rise && sat);

    unique case (state_q)
      IDLE:    if (take)       state_d = REQ;
      REQ:     if (claim_i)    state_d = CLAIMED;
      CLAIMED: if (complete_i) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase

    // A rise coinciding with the consuming transition cancels out.
    if (EDGE) begin
      if (rise && !take) begin
        if (!sat) cnt_d = cnt_q + CNT_W'(1);
      end else if (take && !rise) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign req_o      = (state_q == REQ);
  assign claimed_o  = (state_q == CLAIMED);
  assign edge_ovf_o = ovf_q;

endmodule

// File: rtl/plic_gateway.sv
// Interrupt gateway array in front of the PLIC core; line 0 is reserved and
// never requests.
module plic_gateway
  import uninasoc_pkg::*;
#(
  parameter int unsigned             NUM_SOURCES = PLIC_NUM_SOURCES,
  parameter int unsigned             ID_WIDTH    = PLIC_ID_WIDTH,
  parameter logic [NUM_SOURCES-1:0]  EDGE_MASK   = NUM_SOURCES'(PLIC_EDGE_MASK),
  parameter int unsigned             EDGE_CNT_W  = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_SOURCES-1:0] src_i,
  input  logic                   claim_valid_i,
  input  logic [ID_WIDTH-1:0]    claim_id_i,
  input  logic                   complete_valid_i,
  input  logic [ID_WIDTH-1:0]    complete_id_i,
  output logic [NUM_SOURCES-1:0] req_o,
  output logic [NUM_SOURCES-1:0] claimed_o,
  output logic [NUM_SOURCES-1:0] edge_ovf_o
);

  logic [NUM_SOURCES-1:0] claim_oh;
  logic [NUM_SOURCES-1:0] complete_oh;
  logic                   unused_ok;

  // Bit 0 of each one-hot stays clear, so ID 0 is dropped here.
  always_comb begin
    claim_oh    = '0;
    complete_oh = '0;
    for (int unsigned i = 1; i < NUM_SOURCES; i++) begin
      claim_oh[i]    = claim_valid_i    && (claim_id_i    == ID_WIDTH'(i));
      complete_oh[i] = complete_valid_i && (complete_id_i == ID_WIDTH'(i));
    end
  end

  assign req_o[0]      = 1'b0;
  assign claimed_o[0]  = 1'b0;
  assign edge_ovf_o[0] = 1'b0;
  assign unused_ok     = ^{src_i[0], claim_oh[0], complete_oh[0]};

  for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_src
    plic_gateway_cell #(
      .EDGE  (EDGE_MASK[i]),
      .CNT_W (EDGE_CNT_W)
    ) u_cell (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .src_i      (src_i[i]),
      .claim_i    (claim_oh[i]),
      .complete_i (complete_oh[i]),
      .req_o      (req_o[i]),
      .claimed_o  (claimed_o[i]),
      .edge_ovf_o (edge_ovf_o[i])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: vector table, directed corner cases and
// randomized traffic against a per-source behavioural model.
module tb_plic_gateway;

  localparam int          NS   = 32;
  localparam int          IW   = 5;
  localparam int          CW   = 3;
  localparam int          CMAX = (1 << CW) - 1;
  // Source 2 edge, sources 1, 3, 4 level, plus a few more edge lines.
  localparam logic [31:0] MASK = 32'h0000_F0A4;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] src;
  logic          cv, pv;
  logic [IW-1:0] cid, pid;
  logic [NS-1:0] req_o, claimed_o, edge_ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mask_v = MASK;
  bit          m_req[NS], m_svc[NS], m_ovf[NS], m_prev[NS];
  int          m_cnt[NS];

  always #5 clock = ~clock;

  plic_gateway #(
    .NUM_SOURCES (NS),
    .ID_WIDTH    (IW),
    .EDGE_MASK   (MASK),
    .EDGE_CNT_W  (CW)
  ) dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .src_i            (src),
    .claim_valid_i    (cv),
    .claim_id_i       (cid),
    .complete_valid_i (pv),
    .complete_id_i    (pid),
    .req_o            (req_o),
    .claimed_o        (claimed_o),
    .edge_ovf_o       (edge_ovf_o)
  );

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Each source: at most one request outstanding; edges are queued in a
  // bounded counter and one is consumed per new request.
  task automatic model_update();
    for (int i = 0; i < NS; i++) begin
      bit is_edge, rise, idle, trig, take;
      int c;
      if (reset || i == 0) begin
        m_req[i] = 0; m_svc[i] = 0; m_ovf[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
        continue;
      end
      is_edge = mask_v[i];
      rise    = is_edge && src[i] && !m_prev[i];
      idle    = !m_req[i] && !m_svc[i];
      trig    = is_edge ? (m_cnt[i] > 0) : src[i];
      take    = idle && trig;
      c       = m_cnt[i] + int'(rise) - int'(take && is_edge);
      if (rise && m_cnt[i] == CMAX) m_ovf[i] = 1;
      m_cnt[i]  = (c > CMAX) ? CMAX : c;
      m_prev[i] = src[i];
      if (take) m_req[i] = 1;
      else if (m_req[i] && cv && int'(cid) == i) begin m_req[i] = 0; m_svc[i] = 1; end
      else if (m_svc[i] && pv && int'(pid) == i) m_svc[i] = 0;
    end
  endtask

  task automatic tick();
    logic [31:0] er, ec, eo;
    @(posedge clock);
    model_update();
    #1;
    for (int i = 0; i < NS; i++) begin
      er[i] = m_req[i]; ec[i] = m_svc[i]; eo[i] = m_ovf[i];
    end
    check_vec("model_req", req_o, er);
    check_vec("model_claimed", claimed_o, ec);
    check_vec("model_ovf", edge_ovf_o, eo);
  endtask

  task automatic drive(input logic [31:0] s, input logic c_v, input logic [IW-1:0] c_id,
                       input logic p_v, input logic [IW-1:0] p_id, input logic r);
    src = s; cv = c_v; cid = c_id; pv = p_v; pid = p_id; reset = r;
    tick();
  endtask

  task automatic idle_cyc(input logic [31:0] s);
    drive(s, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_req(input int idx, input logic [31:0] s, output bit found);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (req_o[idx]) found = 1;
      else idle_cyc(s);
    end
  endtask

  task automatic serve(input int idx, input logic [31:0] s, output bit found);
    wait_req(idx, s, found);
    if (found) begin
      drive(s, 1'b1, IW'(idx), 1'b0, '0, 1'b0);
      drive(s, 1'b0, '0, 1'b1, IW'(idx), 1'b0);
    end
  endtask

  task automatic count_rounds(input int idx, input logic [31:0] s, input int max_r, output int got);
    bit f;
    got = 0;
    for (int r = 0; r < max_r; r++) begin
      serve(idx, s, f);
      if (f) got++;
    end
  endtask

  typedef struct {
    logic [31:0]   s;
    logic          c_v;
    logic [IW-1:0] c_id;
    logic          p_v;
    logic [IW-1:0] p_id;
    logic          r;
    logic [31:0]   er;
    logic [31:0]   ec;
  } vec_t;

  vec_t tbl[$];
  bit   f;
  int   got;

  initial begin
    reset = 1'b1; src = '0; cv = 1'b0; cid = '0; pv = 1'b0; pid = '0;

    tbl.push_back('{32'h00, 0, 0, 0, 0, 1, 32'h00, 32'h00});
    tbl.push_back('{32'h10, 0, 0, 0, 0, 0, 32'h10, 32'h00});
    tbl.push_back('{32'h10, 1, 4, 0, 0, 0, 32'h00, 32'h10});
    tbl.push_back('{32'h10, 1, 0, 0, 0, 0, 32'h00, 32'h10});
    tbl.push_back('{32'h10, 0, 0, 1, 4, 0, 32'h00, 32'h00});
    tbl.push_back('{32'h10, 0, 0, 0, 0, 0, 32'h10, 32'h00});
    tbl.push_back('{32'h02, 1, 3, 0, 0, 0, 32'h12, 32'h00});
    tbl.push_back('{32'h02, 0, 0, 1, 1, 0, 32'h12, 32'h00});
    tbl.push_back('{32'h00, 1, 4, 0, 0, 0, 32'h02, 32'h10});
    tbl.push_back('{32'h00, 0, 0, 1, 4, 0, 32'h02, 32'h00});
    tbl.push_back('{32'h00, 0, 0, 0, 0, 0, 32'h02, 32'h00});
    tbl.push_back('{32'h04, 0, 0, 0, 0, 0, 32'h02, 32'h00});
    tbl.push_back('{32'h04, 1, 1, 0, 0, 0, 32'h04, 32'h02});
    tbl.push_back('{32'h00, 1, 2, 0, 0, 0, 32'h00, 32'h06});
    tbl.push_back('{32'h08, 0, 0, 1, 1, 0, 32'h08, 32'h04});
    tbl.push_back('{32'h08, 1, 3, 1, 2, 0, 32'h00, 32'h08});
    tbl.push_back('{32'h02, 1, 1, 1, 3, 0, 32'h02, 32'h00});
    tbl.push_back('{32'h00, 1, 1, 0, 0, 0, 32'h00, 32'h02});
    tbl.push_back('{32'h08, 0, 0, 0, 0, 0, 32'h08, 32'h02});
    tbl.push_back('{32'h00, 1, 3, 0, 0, 0, 32'h00, 32'h0A});
    tbl.push_back('{32'h00, 0, 0, 1, 1, 0, 32'h00, 32'h08});
    tbl.push_back('{32'h02, 0, 0, 0, 0, 0, 32'h02, 32'h08});
    tbl.push_back('{32'h00, 1, 1, 1, 3, 0, 32'h00, 32'h02});

    foreach (tbl[k]) begin
      drive(tbl[k].s, tbl[k].c_v, tbl[k].c_id, tbl[k].p_v, tbl[k].p_id, tbl[k].r);
      check_vec($sformatf("tbl%0d_req", k), req_o, tbl[k].er);
      check_vec($sformatf("tbl%0d_claimed", k), claimed_o, tbl[k].ec);
    end

    // Three edges queued while in service yield exactly three more requests.
    drive('0, 0, '0, 0, '0, 1);
    idle_cyc(32'h04);
    serve(2, 32'h0, f);
    check_int("edge_first_req", int'(f), 1);
    drive('0, 0, '0, 0, '0, 1);
    idle_cyc(32'h04);
    wait_req(2, 32'h0, f);
    drive('0, 1, IW'(2), 0, '0, 0);
    for (int k = 0; k < 3; k++) begin idle_cyc(32'h04); idle_cyc(32'h00); end
    drive('0, 0, '0, 1, IW'(2), 0);
    count_rounds(2, 32'h0, 4, got);
    check_int("edge_rounds", got, 3);

    // Nine edges in service saturate the counter at seven and set overflow.
    drive('0, 0, '0, 0, '0, 1);
    idle_cyc(32'h04);
    wait_req(2, 32'h0, f);
    drive('0, 1, IW'(2), 0, '0, 0);
    for (int k = 0; k < 9; k++) begin idle_cyc(32'h04); idle_cyc(32'h00); end
    check_vec("ovf_set", edge_ovf_o, 32'h04);
    drive('0, 0, '0, 1, IW'(2), 0);
    count_rounds(2, 32'h0, 9, got);
    check_int("ovf_rounds", got, 7);
    check_vec("ovf_sticky", edge_ovf_o, 32'h04);
    drive('0, 0, '0, 0, '0, 1);
    check_vec("ovf_reset", edge_ovf_o, 32'h00);

    // Rise in the same cycle as the IDLE->REQ consume keeps the count.
    idle_cyc(32'h04);
    wait_req(2, 32'h0, f);
    drive('0, 1, IW'(2), 0, '0, 0);
    idle_cyc(32'h04);
    idle_cyc(32'h00);
    drive('0, 0, '0, 1, IW'(2), 0);
    idle_cyc(32'h04);
    check_vec("simul_rise_req", req_o, 32'h04);
    count_rounds(2, 32'h0, 3, got);
    check_int("simul_rise_rounds", got, 2);

    // Reset with sources busy, then an edge line held high across reset.
    drive('0, 0, '0, 0, '0, 1);
    idle_cyc(32'h04);
    idle_cyc(32'h00);
    drive('0, 1, IW'(2), 0, '0, 0);
    idle_cyc(32'h04);
    idle_cyc(32'h00);
    idle_cyc(32'h06);
    check_vec("pre_reset_req", req_o, 32'h02);
    check_vec("pre_reset_claimed", claimed_o, 32'h04);
    drive(32'h04, 0, '0, 0, '0, 1);
    check_vec("reset_req", req_o, 32'h00);
    check_vec("reset_claimed", claimed_o, 32'h00);
    count_rounds(2, 32'h04, 3, got);
    check_int("post_reset_rounds", got, 1);

    // Randomized traffic against the model.
    drive('0, 0, '0, 0, '0, 1);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] s;
      s = src ^ ($urandom() & $urandom() & $urandom());
      drive(s,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(1, 5)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(1, 5)),
            1'($urandom_range(0, 299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
